// File: rtl/rtype_exec.sv
`default_nettype none
// ============================================================================
// Module   : rtype_exec
// Brief    : Two-stage (EX, WB) MIPS R-type ALU pipeline with a 32x32
//            register file, EX-to-EX operand bypass and a preload port.
// Revision : 1.0 - initial release
// ============================================================================
module rtype_exec (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  func,
  input  logic        ld_en,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic        ovf,
  output logic [15:0] retired,
  output logic [15:0] illegal
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_FUNC_ADD = 6'b100000;
  localparam logic [5:0] c_FUNC_SUB = 6'b100010;
  localparam logic [5:0] c_FUNC_AND = 6'b100100;
  localparam logic [5:0] c_FUNC_OR  = 6'b100101;
  localparam logic [5:0] c_FUNC_XOR = 6'b100110;
  localparam logic [5:0] c_FUNC_SLT = 6'b101010;

  logic [31:0] r_regs [32];
  logic        r_ex_valid;
  logic [4:0]  r_ex_rd;
  logic [31:0] r_ex_result;
  logic [31:0] r_alu_out;
  logic        r_zero;
  logic        r_ovf;
  logic [15:0] r_retired;
  logic [15:0] r_illegal;

  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_result;
  logic        w_is_rtype;
  logic        w_supported;
  logic        w_overflow;
  logic        w_exec;

  // Register 0 short-circuits first, so a stale ex_rd==0 can never bypass.
  assign w_op_a = (rs == 5'd0) ? 32'd0 :
                  (r_ex_valid && (r_ex_rd == rs)) ? r_ex_result : r_regs[rs];
  assign w_op_b = (rt == 5'd0) ? 32'd0 :
                  (r_ex_valid && (r_ex_rd == rt)) ? r_ex_result : r_regs[rt];

  assign w_sum      = w_op_a + w_op_b;
  assign w_diff     = w_op_a - w_op_b;
  assign w_is_rtype = (op == c_OP_RTYPE);

  always_comb begin
    w_result    = 32'd0;
    w_supported = 1'b0;
    w_overflow  = 1'b0;
    case (func)
      c_FUNC_ADD: begin
        w_supported = 1'b1;
        w_result    = w_sum;
        w_overflow  = (w_op_a[31] == w_op_b[31]) && (w_sum[31] != w_op_a[31]);
      end
      c_FUNC_SUB: begin
        w_supported = 1'b1;
        w_result    = w_diff;
        w_overflow  = (w_op_a[31] != w_op_b[31]) && (w_diff[31] != w_op_a[31]);
      end
      c_FUNC_AND: begin
        w_supported = 1'b1;
        w_result    = w_op_a & w_op_b;
      end
      c_FUNC_OR: begin
        w_supported = 1'b1;
        w_result    = w_op_a | w_op_b;
      end
      c_FUNC_XOR: begin
        w_supported = 1'b1;
        w_result    = w_op_a ^ w_op_b;
      end
      c_FUNC_SLT: begin
        w_supported = 1'b1;
        w_result    = {31'd0, ($signed(w_op_a) < $signed(w_op_b))};
      end
      default: begin
        w_supported = 1'b0;
      end
    endcase
  end

  assign w_exec = w_is_rtype && w_supported && !w_overflow;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= 5'd0;
      r_ex_result <= 32'd0;
      r_alu_out   <= 32'd0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_retired   <= 16'd0;
      r_illegal   <= 16'd0;
    end else begin
      r_ex_valid <= w_exec;
      if (w_exec) begin
        r_ex_rd     <= rd;
        r_ex_result <= w_result;
        r_alu_out   <= w_result;
        r_zero      <= (w_result == 32'd0);
        r_retired   <= r_retired + 16'd1;
      end
      if (w_is_rtype && w_supported && w_overflow) begin
        r_ovf <= 1'b1;
      end
      if (w_is_rtype && !w_supported) begin
        r_illegal <= r_illegal + 16'd1;
      end
    end
  end

  // Write-back is assigned after preload so it wins on an index collision.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else begin
      if (ld_en && (ld_addr != 5'd0)) begin
        r_regs[ld_addr] <= ld_data;
      end
      if (r_ex_valid && (r_ex_rd != 5'd0)) begin
        r_regs[r_ex_rd] <= r_ex_result;
      end
    end
  end

  assign dbg_data = r_regs[dbg_addr];
  assign alu_out  = r_alu_out;
  assign zero     = r_zero;
  assign ovf      = r_ovf;
  assign retired  = r_retired;
  assign illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_rtype_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtype_exec
// Brief    : Directed scoreboard bench for rtype_exec.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtype_exec;

  localparam logic [5:0] c_NOP = 6'h01;
  localparam logic [5:0] c_ADD = 6'h20;
  localparam logic [5:0] c_SUB = 6'h22;
  localparam logic [5:0] c_AND = 6'h24;
  localparam logic [5:0] c_OR  = 6'h25;
  localparam logic [5:0] c_XOR = 6'h26;
  localparam logic [5:0] c_SLT = 6'h2A;

  logic        Clk;
  logic        Rst;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  func;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] alu_out;
  logic        zero;
  logic        ovf;
  logic [15:0] retired;
  logic [15:0] illegal;

  typedef struct {
    int          id;
    logic [31:0] alu;
    logic        z;
    logic        o;
    logic [15:0] ret;
    logic [15:0] ill;
    logic [4:0]  da;
    logic [31:0] dbg;
  } exp_t;

  exp_t q[$];
  int   n_checks;
  int   n_fail;
  int   n_issued;

  rtype_exec dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .func     (func),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .alu_out  (alu_out),
    .zero     (zero),
    .ovf      (ovf),
    .retired  (retired),
    .illegal  (illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: one expectation per clock, sampled 1 time unit after the edge.
  exp_t e;
  always @(posedge Clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("alu_out", e.id, alu_out, e.alu);
      chk("zero", e.id, {31'd0, zero}, {31'd0, e.z});
      chk("ovf", e.id, {31'd0, ovf}, {31'd0, e.o});
      chk("retired", e.id, {16'd0, retired}, {16'd0, e.ret});
      chk("illegal", e.id, {16'd0, illegal}, {16'd0, e.ill});
      chk("dbg_data", e.id, dbg_data, e.dbg);
    end
  end

  // Drive one instruction word (plus preload/debug) on the negedge and queue
  // the outputs expected right after the following posedge.
  task automatic cyc(input logic [5:0] o, input logic [5:0] f,
                     input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                     input logic le, input logic [4:0] la, input logic [31:0] lv,
                     input logic [4:0] da, input logic [31:0] xdbg,
                     input logic [31:0] xalu, input logic xz, input logic xo,
                     input logic [15:0] xr, input logic [15:0] xi);
    exp_t x;
    @(negedge Clk);
    op = o; func = f; rs = s; rt = t; rd = d;
    ld_en = le; ld_addr = la; ld_data = lv; dbg_addr = da;
    x.id = n_issued; x.alu = xalu; x.z = xz; x.o = xo; x.ret = xr; x.ill = xi;
    x.da = da; x.dbg = xdbg;
    q.push_back(x);
    n_issued++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; n_issued = 0;
    Rst = 1'b1;
    op = c_NOP; func = 6'h00; rs = 5'd0; rt = 5'd0; rd = 5'd0;
    ld_en = 1'b0; ld_addr = 5'd0; ld_data = 32'd0; dbg_addr = 5'd0;

    // Reset state
    cyc(c_NOP, 6'h00, 0, 0, 0, 0, 0, 0, 5, 32'd0, 32'd0, 0, 0, 16'd0, 16'd0);
    @(posedge Clk); #2; Rst = 1'b0;

    // Basic ALU
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 1, 32'd5, 1, 32'd5, 32'd0, 0, 0, 16'd0, 16'd0);
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 2, 32'd3, 2, 32'd3, 32'd0, 0, 0, 16'd0, 16'd0);
    cyc(6'h00, c_ADD, 1, 2, 3, 0, 0, 0, 3, 32'd0, 32'd8, 0, 0, 16'd1, 16'd0);
    cyc(6'h00, c_SUB, 2, 1, 4, 0, 0, 0, 3, 32'd8, 32'hFFFF_FFFE, 0, 0, 16'd2, 16'd0);
    cyc(6'h00, c_SLT, 4, 1, 5, 0, 0, 0, 4, 32'hFFFF_FFFE, 32'd1, 0, 0, 16'd3, 16'd0);
    cyc(6'h00, c_AND, 1, 2, 6, 0, 0, 0, 5, 32'd1, 32'd1, 0, 0, 16'd4, 16'd0);
    cyc(6'h00, c_OR,  1, 2, 7, 0, 0, 0, 6, 32'd1, 32'd7, 0, 0, 16'd5, 16'd0);
    cyc(6'h00, c_XOR, 1, 2, 8, 0, 0, 0, 7, 32'd7, 32'd6, 0, 0, 16'd6, 16'd0);
    cyc(c_NOP, 6'h00, 0, 0, 0, 0, 0, 0, 8, 32'd6, 32'd6, 0, 0, 16'd6, 16'd0);

    // Bypass chain
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 1, 32'd1, 1, 32'd1, 32'd6, 0, 0, 16'd6, 16'd0);
    cyc(6'h00, c_ADD, 1, 1, 2, 0, 0, 0, 2, 32'd3, 32'd2, 0, 0, 16'd7, 16'd0);
    cyc(6'h00, c_ADD, 2, 2, 3, 0, 0, 0, 2, 32'd2, 32'd4, 0, 0, 16'd8, 16'd0);
    cyc(6'h00, c_ADD, 3, 3, 4, 0, 0, 0, 3, 32'd4, 32'd8, 0, 0, 16'd9, 16'd0);
    cyc(c_NOP, 6'h00, 0, 0, 0, 0, 0, 0, 4, 32'd8, 32'd8, 0, 0, 16'd9, 16'd0);

    // Overflow (add, then sub) is a sticky flag and a bubble
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 1, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 32'd8, 0, 0, 16'd9, 16'd0);
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 2, 32'd1, 2, 32'd1, 32'd8, 0, 0, 16'd9, 16'd0);
    cyc(6'h00, c_ADD, 1, 2, 3, 0, 0, 0, 3, 32'd4, 32'd8, 0, 1, 16'd9, 16'd0);
    cyc(c_NOP, 6'h00, 0, 0, 0, 0, 0, 0, 3, 32'd4, 32'd8, 0, 1, 16'd9, 16'd0);
    cyc(6'h00, c_SUB, 1, 2, 9, 0, 0, 0, 3, 32'd4, 32'h7FFF_FFFE, 0, 1, 16'd10, 16'd0);
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 10, 32'h8000_0000, 9, 32'h7FFF_FFFE, 32'h7FFF_FFFE, 0, 1, 16'd10, 16'd0);
    cyc(6'h00, c_SUB, 10, 2, 11, 0, 0, 0, 10, 32'h8000_0000, 32'h7FFF_FFFE, 0, 1, 16'd10, 16'd0);
    cyc(c_NOP, 6'h00, 0, 0, 0, 0, 0, 0, 11, 32'd0, 32'h7FFF_FFFE, 0, 1, 16'd10, 16'd0);

    // Zero register, non-R-type bubble, illegal func
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 1, 32'd5, 1, 32'd5, 32'h7FFF_FFFE, 0, 1, 16'd10, 16'd0);
    cyc(6'h00, c_ADD, 1, 2, 0, 0, 0, 0, 0, 32'd0, 32'd6, 0, 1, 16'd11, 16'd0);
    cyc(6'h23, c_ADD, 1, 2, 3, 0, 0, 0, 0, 32'd0, 32'd6, 0, 1, 16'd11, 16'd0);
    cyc(6'h00, 6'h3F, 1, 2, 3, 0, 0, 0, 3, 32'd4, 32'd6, 0, 1, 16'd11, 16'd1);

    // After a bubble the operand comes from the file, not stale ex_result
    cyc(6'h00, c_ADD, 1, 2, 12, 0, 0, 0, 12, 32'd0, 32'd6, 0, 1, 16'd12, 16'd1);
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 12, 32'd100, 12, 32'd6, 32'd6, 0, 1, 16'd12, 16'd1);
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 12, 32'd100, 12, 32'd100, 32'd6, 0, 1, 16'd12, 16'd1);
    cyc(6'h00, c_ADD, 12, 0, 13, 0, 0, 0, 13, 32'd0, 32'd100, 0, 1, 16'd13, 16'd1);

    // Preload collisions
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 1, 32'd8, 13, 32'd100, 32'd100, 0, 1, 16'd13, 16'd1);
    cyc(6'h00, c_ADD, 1, 2, 6, 0, 0, 0, 1, 32'd8, 32'd9, 0, 1, 16'd14, 16'd1);
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 6, 32'd42, 6, 32'd9, 32'd9, 0, 1, 16'd14, 16'd1);
    cyc(6'h00, c_ADD, 2, 2, 6, 0, 0, 0, 6, 32'd9, 32'd2, 0, 1, 16'd15, 16'd1);
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 7, 32'd42, 6, 32'd2, 32'd2, 0, 1, 16'd15, 16'd1);
    cyc(c_NOP, 6'h00, 0, 0, 0, 0, 0, 0, 7, 32'd42, 32'd2, 0, 1, 16'd15, 16'd1);

    // Zero flag
    cyc(6'h00, c_SUB, 1, 1, 14, 0, 0, 0, 7, 32'd42, 32'd0, 1, 1, 16'd16, 16'd1);
    cyc(c_NOP, 6'h00, 0, 0, 0, 0, 0, 0, 14, 32'd0, 32'd0, 1, 1, 16'd16, 16'd1);

    // Reset with a write-back in flight
    cyc(6'h00, c_ADD, 1, 2, 15, 0, 0, 0, 15, 32'd0, 32'd9, 0, 1, 16'd17, 16'd1);
    @(posedge Clk); #2; Rst = 1'b1;
    cyc(c_NOP, 6'h00, 0, 0, 0, 0, 0, 0, 15, 32'd0, 32'd0, 0, 0, 16'd0, 16'd0);
    @(posedge Clk); #2; Rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cyc(c_NOP, 6'h00, 0, 0, 0, 0, 0, 0, i[4:0], 32'd0, 32'd0, 0, 0, 16'd0, 16'd0);
    end

    // Normal operation resumes after reset
    cyc(c_NOP, 6'h00, 0, 0, 0, 1, 1, 32'd3, 1, 32'd3, 32'd0, 0, 0, 16'd0, 16'd0);
    cyc(6'h00, c_ADD, 1, 1, 2, 0, 0, 0, 2, 32'd0, 32'd6, 0, 0, 16'd1, 16'd0);
    cyc(c_NOP, 6'h00, 0, 0, 0, 0, 0, 0, 2, 32'd6, 32'd6, 0, 0, 16'd1, 16'd0);

    repeat (3) @(posedge Clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rtype_exec.md
# rtype_exec

Execute/write-back stage directly downstream of the instruction fetch/decode stage. It consumes the decoded fields `op`, `rs`, `rt`, `rd` and `func` every clock, and holds the 32x32 general register file. It executes MIPS R-type ALU instructions in a two-stage pipeline (EX, then WB) with EX-to-EX operand bypass. A preload port lets the bench or boot logic seed register contents.

## Interface
- No parameters; widths fixed (32-bit data, 32 registers).
- `Clk`  in  1  clock; all state updates on posedge (fetch stage updates fields on negedge, so fields are stable at posedge)
- `Rst`  in  1  reset, asynchronous, active-high
- `op`  in  6  opcode field
- `rs`  in  5  source register 1 index
- `rt`  in  5  source register 2 index
- `rd`  in  5  destination register index
- `func`  in  6  function field
- `ld_en`  in  1  preload write enable
- `ld_addr`  in  5  preload register index
- `ld_data`  in  32  preload data
- `dbg_addr`  in  5  debug read index
- `dbg_data`  out  32  combinational read of `regfile[dbg_addr]`, no bypass
- `alu_out`  out  32  registered EX result
- `zero`  out  1  registered, 1 when last executed result == 0
- `ovf`  out  1  sticky signed-overflow flag
- `retired`  out  16  count of executed supported instructions
- `illegal`  out  16  count of op==0 words with unsupported func

## Operation
- Decode at posedge k. When op==6'b000000, the supported func values are:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 100110 xor
  - 101010 slt (signed, result 0 or 1)
- op==0 with any other func: bubble; `illegal` += 1 (wraps at 16'hFFFF).
- op!=0: bubble; no counter changes.
- Operand read for A (`rs`):
  - If rs==0, A=0.
  - Else if `ex_valid` && `ex_rd`==rs, A=`ex_result` (bypass).
  - Else A=`regfile[rs]`.
- Operand read for B (`rt`): same rules as A.
- Arithmetic is 32-bit two's complement. Overflow occurs when:
  - add: A and B have the same sign and the result sign differs.
  - sub: A and B have different signs and the result sign differs from A.
- Overflowing add/sub:
  - Sets `ovf` (sticky until reset).
  - Is treated as a bubble: no write-back, no `retired` increment, `alu_out`/`zero` unchanged.
- Supported, non-overflowing instruction at posedge k:
  - `ex_valid`<=1, `ex_rd`<=rd, `ex_result`<=result.
  - `alu_out`<=result, `zero`<=(result==0).
  - `retired`+=1 (wraps).
- Bubble at posedge k: `ex_valid`<=0; `alu_out` and `zero` hold.
- WB at posedge k+1: if `ex_valid` && `ex_rd`!=0, `regfile[ex_rd]`<=`ex_result`.
- rd==0: executes and counts, but never writes; `regfile[0]` is always 0. Bypass from `ex_rd`==0 is never taken.
- Preload: at posedge with `ld_en`=1 and `ld_addr`!=0, `regfile[ld_addr]`<=`ld_data`.
  - If WB targets the same index at the same edge, WB wins.
  - Preload and WB to different indices both occur.

## Timing
- Reset (async, immediate):
  - All 32 registers = 0, `ex_valid`=0, `ex_rd`=0, `ex_result`=0.
  - `alu_out`=0, `zero`=0, `ovf`=0, `retired`=0, `illegal`=0.
  - `dbg_data` therefore reads 0.
- Reset asserted mid-pipeline discards the in-flight EX result; no write occurs after `Rst` deasserts.
- Latency:
  - Fields sampled at posedge k: `alu_out` valid after posedge k.
  - Register file updated at posedge k+1; visible on `dbg_data` after posedge k+1.
- Back-to-back dependent instructions (consumer at k+1 reads `rd` of k) use the bypass; there are no stalls and throughput is 1 instruction/clock.
- Consumer at k+2 reads the register file directly (already written at k+1).
- Preload at posedge k is seen by an instruction sampled at posedge k+1, not at k (there is no preload bypass).

## Test plan
- Reset check: assert `Rst` mid-run with `ex_valid`=1 -> all outputs 0; `dbg_data` for every index reads 0; the pending WB never appears.
- Basic ALU:
  - Preload r1=5, r2=3.
  - add r3,r1,r2 -> `alu_out`=8, `dbg_data`(3)=8 one cycle later.
  - sub r4,r2,r1 -> 32'hFFFFFFFE.
  - slt r5,r4,r1 -> 1.
  - and/or/xor r1,r2 -> 1/7/6.
- Bypass chain: preload r1=1; add r2,r1,r1 then add r3,r2,r2 then add r4,r3,r3 on consecutive clocks -> `alu_out` 2, 4, 8; `retired`=3.
- Overflow: r1=32'h7FFFFFFF, r2=1, add r3,r1,r2 -> `ovf`=1 and stays 1; r3 unchanged; `alu_out`/`retired` unchanged; next valid instruction executes normally.
- Zero register and bubbles:
  - add r0,r1,r2 -> `regfile[0]` stays 0 and `retired`+1.
  - Then op=6'h23 -> no counter change.
  - Then op=0, func=6'h3F -> `illegal`=1.
  - Dependent instruction after a bubble reads the register file, not stale `ex_result`.
- Preload collision: WB to r6=9 and preload r6=42 at the same edge -> r6=9. Preload r7=42 while WB r6 -> both written.
